// File: rtl/pong_pkg.sv
// Shared types and helpers for the paddle controllers.
package pong_pkg;

  localparam int POS_W_DEF = 9;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } dir_t;

  // Integer-wide arithmetic so neither the sum nor the difference can wrap.
  function automatic int sat_move(input int pos, input int step, input int limit, input logic up);
    int res;
    if (up) res = (pos + step > limit) ? limit : pos + step;
    else    res = (pos < step) ? 0 : pos - step;
    return res;
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: left-edge position with hold-to-accelerate stepping and recentre.
//
//   last_dir | meaning
//   NONE     | no key held on the previous tick (or recentred / reset)
//   LEFT     | previous tick moved left; hold_cnt counts the run
//   RIGHT    | previous tick moved right; hold_cnt counts the run
module paddle_channel
  import pong_pkg::*;
#(
  parameter int POS_W       = POS_W_DEF,
  parameter int MAX_LEFT    = 200,
  parameter int INIT_POS    = 100,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             recentre,
  output logic [POS_W-1:0] left_pos
);

  localparam int HW = $clog2(ACCEL_TICKS + 1);
  localparam logic [HW-1:0] HOLD_SAT = HW'(ACCEL_TICKS);

  logic [HW-1:0]    hold_cnt, hold_nxt;
  dir_t             last_dir, dir_nxt, dir;
  logic [POS_W-1:0] pos_nxt;
  int               step;

  always_comb begin
    pos_nxt  = left_pos;
    hold_nxt = hold_cnt;
    dir_nxt  = last_dir;
    step     = STEP_MIN;
    dir      = NONE;
    if (key_left && !key_right)      dir = LEFT;
    else if (key_right && !key_left) dir = RIGHT;

    if (recentre) begin
      pos_nxt  = POS_W'(INIT_POS);
      hold_nxt = '0;
      dir_nxt  = NONE;
    end else if (tick) begin
      if (dir == NONE) begin
        hold_nxt = '0;
        dir_nxt  = NONE;
      end else begin
        if (dir != last_dir) begin
          hold_nxt = HW'(1);
        end else begin
          // Full speed only once the run has already saturated.
          step     = (hold_cnt == HOLD_SAT) ? STEP_MAX : STEP_MIN;
          hold_nxt = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HW'(1);
        end
        pos_nxt = POS_W'(sat_move(int'(left_pos), step, MAX_LEFT, dir == RIGHT));
        dir_nxt = dir;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      left_pos <= POS_W'(INIT_POS);
      hold_cnt <= '0;
      last_dir <= NONE;
    end else begin
      left_pos <= pos_nxt;
      hold_cnt <= hold_nxt;
      last_dir <= dir_nxt;
    end
  end

endmodule

// File: rtl/paddle_bank.sv
// Bank of independent paddle channels sharing one movement-tick divider.
module paddle_bank
  import pong_pkg::*;
#(
  parameter int NUM_PADDLES = 2,
  parameter int POS_W       = POS_W_DEF,
  parameter int FIELD_W     = 240,
  parameter int PADDLE_LEN  = 40,
  parameter int INIT_POS    = 100,
  parameter int TICK_DIV    = 4,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PADDLES-1:0]       key_left,
  input  logic [NUM_PADDLES-1:0]       key_right,
  input  logic [NUM_PADDLES-1:0]       recentre,
  output logic [NUM_PADDLES*POS_W-1:0] left_pos,
  output logic [NUM_PADDLES*POS_W-1:0] centre_pos,
  output logic [NUM_PADDLES-1:0]       at_left,
  output logic [NUM_PADDLES-1:0]       at_right,
  output logic                         move_tick
);

  localparam int MAX_LEFT = FIELD_W - PADDLE_LEN;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if (PADDLE_LEN > FIELD_W)     begin : g_chk_len   $error("PADDLE_LEN exceeds FIELD_W"); end
  if (INIT_POS > MAX_LEFT)      begin : g_chk_init  $error("INIT_POS beyond MAX_LEFT"); end
  if (FIELD_W >= (1 << POS_W))  begin : g_chk_width $error("FIELD_W does not fit in POS_W"); end
  if (STEP_MIN > STEP_MAX)      begin : g_chk_step  $error("STEP_MIN exceeds STEP_MAX"); end
  if (TICK_DIV < 1)             begin : g_chk_div   $error("TICK_DIV must be >= 1"); end
  if (ACCEL_TICKS < 1)          begin : g_chk_accel $error("ACCEL_TICKS must be >= 1"); end

  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                         tick_cnt <= tick_cnt + 1'b1;
  end

  // Gated by reset so a divide-by-one divider stays quiet while held in reset.
  assign move_tick = reset && (tick_cnt == TICK_LAST);

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
    paddle_channel #(
      .POS_W      (POS_W),
      .MAX_LEFT   (MAX_LEFT),
      .INIT_POS   (INIT_POS),
      .STEP_MIN   (STEP_MIN),
      .STEP_MAX   (STEP_MAX),
      .ACCEL_TICKS(ACCEL_TICKS)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .tick     (move_tick),
      .key_left (key_left[i]),
      .key_right(key_right[i]),
      .recentre (recentre[i]),
      .left_pos (left_pos[i*POS_W +: POS_W])
    );

    assign centre_pos[i*POS_W +: POS_W] = left_pos[i*POS_W +: POS_W] + POS_W'(PADDLE_LEN/2 - 1);
    assign at_left[i]  = (left_pos[i*POS_W +: POS_W] == '0);
    assign at_right[i] = (left_pos[i*POS_W +: POS_W] == POS_W'(MAX_LEFT));
  end

endmodule

// File: tb/tb_paddle_bank.sv
// Randomized bench for paddle_bank against a run-length reference model.
module tb_paddle_bank;

  localparam int NP     = 2;
  localparam int PW     = 9;
  localparam int FW     = 240;
  localparam int PL     = 40;
  localparam int INIT   = 100;
  localparam int DIV    = 4;
  localparam int SMIN   = 1;
  localparam int SMAX   = 4;
  localparam int ACCEL  = 8;
  localparam int MAXL   = FW - PL;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NP-1:0]     key_left  = '0;
  logic [NP-1:0]     key_right = '0;
  logic [NP-1:0]     recentre  = '0;
  logic [NP*PW-1:0]  left_pos, centre_pos;
  logic [NP-1:0]     at_left, at_right;
  logic              move_tick;

  paddle_bank #(
    .NUM_PADDLES(NP), .POS_W(PW), .FIELD_W(FW), .PADDLE_LEN(PL), .INIT_POS(INIT),
    .TICK_DIV(DIV), .STEP_MIN(SMIN), .STEP_MAX(SMAX), .ACCEL_TICKS(ACCEL)
  ) dut (
    .clock(clock), .reset(reset), .key_left(key_left), .key_right(key_right),
    .recentre(recentre), .left_pos(left_pos), .centre_pos(centre_pos),
    .at_left(at_left), .at_right(at_right), .move_tick(move_tick)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: direction as -1/0/+1 and the length of the current same-direction run.
  int mpos [NP];
  int mrun [NP];
  int mdir [NP];
  int phase;

  int seg_len  [NP];
  int seg_mode [NP];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dut_pos(input int i);
    logic [PW-1:0] v;
    v = left_pos[i*PW +: PW];
    return int'(v);
  endfunction

  function automatic int dut_ctr(input int i);
    logic [PW-1:0] v;
    v = centre_pos[i*PW +: PW];
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mpos[i] = INIT; mrun[i] = 0; mdir[i] = 0;
    end
    phase = 0;
  endtask

  task automatic model_edge(input logic [NP-1:0] kl, input logic [NP-1:0] kr, input logic [NP-1:0] rc);
    bit tick;
    int d, st, np;
    tick  = (phase == DIV - 1);
    phase = (phase + 1) % DIV;
    for (int i = 0; i < NP; i++) begin
      if (rc[i]) begin
        mpos[i] = INIT; mrun[i] = 0; mdir[i] = 0;
      end else if (tick) begin
        d = (kl[i] && !kr[i]) ? -1 : ((kr[i] && !kl[i]) ? 1 : 0);
        if (d == 0) begin
          mrun[i] = 0; mdir[i] = 0;
        end else begin
          st = (d == mdir[i] && mrun[i] >= ACCEL) ? SMAX : SMIN;
          mrun[i] = (d == mdir[i]) ? mrun[i] + 1 : 1;
          mdir[i] = d;
          np = mpos[i] + d * st;
          if (np < 0) np = 0;
          if (np > MAXL) np = MAXL;
          mpos[i] = np;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("move_tick", int'(move_tick), (reset && phase == DIV - 1) ? 1 : 0);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("left_pos[%0d]", i), dut_pos(i), mpos[i]);
      chk($sformatf("centre_pos[%0d]", i), dut_ctr(i), mpos[i] + PL/2 - 1);
      chk($sformatf("at_left[%0d]", i), int'(at_left[i]), (mpos[i] == 0) ? 1 : 0);
      chk($sformatf("at_right[%0d]", i), int'(at_right[i]), (mpos[i] == MAXL) ? 1 : 0);
    end
  endtask

  // Called at a negedge: check, apply inputs, advance model, cross the posedge.
  task automatic step_cycle(input logic [NP-1:0] kl, input logic [NP-1:0] kr, input logic [NP-1:0] rc);
    check_outputs();
    key_left = kl; key_right = kr; recentre = rc;
    model_edge(kl, kr, rc);
    @(negedge clock);
  endtask

  task automatic random_cycles(input int n, input int rc_odds);
    logic [NP-1:0] kl, kr, rc;
    for (int c = 0; c < n; c++) begin
      kl = '0; kr = '0; rc = '0;
      for (int i = 0; i < NP; i++) begin
        if (seg_len[i] == 0) begin
          int r;
          r = $urandom_range(0, 9);
          seg_mode[i] = (r == 0) ? 0 : (r == 1) ? 3 : (r < 6) ? 1 : 2;
          seg_len[i]  = $urandom_range(4, 120);
        end
        seg_len[i]--;
        kl[i] = (seg_mode[i] == 1 || seg_mode[i] == 3);
        kr[i] = (seg_mode[i] == 2 || seg_mode[i] == 3);
        rc[i] = ($urandom_range(0, rc_odds - 1) == 0);
      end
      step_cycle(kl, kr, rc);
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NP; i++) begin
      seg_len[i] = 0; seg_mode[i] = 0;
    end

    #12;
    chk("reset_pos0", dut_pos(0), INIT);
    chk("reset_ctr1", dut_ctr(1), 119);
    chk("reset_tick", int'(move_tick), 0);
    @(negedge clock);
    reset = 1'b1;

    // Hold RIGHT on channel 0 for ten ticks: 1-pixel steps then full speed.
    for (int c = 0; c < 10 * DIV; c++) step_cycle(2'b00, 2'b01, 2'b00);
    chk("ramp_ch0", dut_pos(0), 116);
    chk("ramp_ch1", dut_pos(1), INIT);

    // Both keys for one tick clears acceleration.
    for (int c = 0; c < DIV; c++) step_cycle(2'b01, 2'b01, 2'b00);
    for (int c = 0; c < DIV; c++) step_cycle(2'b00, 2'b01, 2'b00);
    chk("both_then_right", dut_pos(0), 117);

    // Run channel 0 into the right edge and channel 1 into the left edge.
    for (int c = 0; c < 60 * DIV; c++) step_cycle(2'b10, 2'b01, 2'b00);
    chk("sat_right", dut_pos(0), MAXL);
    chk("sat_left", dut_pos(1), 0);
    chk("flag_right", int'(at_right[0]), 1);
    chk("flag_left", int'(at_left[1]), 1);

    // Recentre channel 1 on a non-tick cycle mid-ramp; next RIGHT tick steps by 1.
    for (int c = 0; c < 12 * DIV; c++) step_cycle(2'b00, 2'b10, 2'b00);
    while (phase == DIV - 1) step_cycle(2'b00, 2'b10, 2'b00);
    step_cycle(2'b00, 2'b10, 2'b10);
    chk("recentre_ch1", dut_pos(1), INIT);
    for (int c = 0; c < DIV; c++) step_cycle(2'b00, 2'b10, 2'b00);
    chk("recentre_step", dut_pos(1), INIT + 1);

    random_cycles(3000, 60);

    // Asynchronous reset between edges while moving.
    for (int c = 0; c < 20 * DIV; c++) step_cycle(2'b01, 2'b10, 2'b00);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_pos0", dut_pos(0), INIT);
    chk("async_pos1", dut_pos(1), INIT);
    chk("async_tick", int'(move_tick), 0);
    @(negedge clock);
    @(negedge clock);
    key_left = '0; key_right = '0; recentre = '0;
    check_outputs();
    reset = 1'b1;

    random_cycles(3000, 200);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
